slice_stream_loader: RTL and testbench

- Feeds the Keccak-style FPGA datapath/controller pair with 64 x 25-bit state slices and collects the processed results.
- Reads slices from a synchronous input memory and presents each on line/count.
- Waits for the controller to consume the slice and for the datapath to report completion.
- Writes the datapath's 25-bit mem result to an output memory at the same index, replacing file-driven slice feeding.

---
 rtl/slice_stream_loader_pkg.sv | 16 +
 rtl/slice_stream_loader_if.sv | 36 +++
 rtl/slice_stream_loader_index_counter.sv | 29 ++
 rtl/slice_stream_loader.sv | 152 +++++++++++++++
 tb/tb_slice_stream_loader.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/slice_stream_loader_pkg.sv
// Shared constants and FSM state encoding for the slice stream loader.
package slice_stream_loader_pkg;

    localparam int WIDTH  = 25;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_PRESENT = 3'd3;
    localparam logic [2:0] S_EXEC    = 3'd4;
    localparam logic [2:0] S_NEXT    = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

endpackage

// File: rtl/slice_stream_loader_if.sv
// Bus bundle between the loader (master) and its memories, controller and datapath (slave).
interface slice_stream_loader_if;
    import slice_stream_loader_pkg::*;

    // Handshakes: line_valid marks line/count as a held slice; readLine is a one-cycle
    // consume pulse honoured only while a slice is presented; ok is a one-cycle pulse
    // that qualifies result; out_wr_en and finished are single-cycle strobes.
    logic              start;
    logic              in_rd_en;
    logic [ADDR_W-1:0] in_rd_addr;
    logic [WIDTH-1:0]  in_rd_data;
    logic [WIDTH-1:0]  line;
    logic [ADDR_W-1:0] count;
    logic              line_valid;
    logic              readLine;
    logic              ok;
    logic [WIDTH-1:0]  result;
    logic              out_wr_en;
    logic [ADDR_W-1:0] out_wr_addr;
    logic [WIDTH-1:0]  out_wr_data;
    logic              busy;
    logic              finished;

    modport master (
        input  start, in_rd_data, readLine, ok, result,
        output in_rd_en, in_rd_addr, line, count, line_valid,
               out_wr_en, out_wr_addr, out_wr_data, busy, finished
    );

    modport slave (
        output start, in_rd_data, readLine, ok, result,
        input  in_rd_en, in_rd_addr, line, count, line_valid,
               out_wr_en, out_wr_addr, out_wr_data, busy, finished
    );

endinterface

// File: rtl/slice_stream_loader_index_counter.sv
// Slice index counter: clear, saturating increment and a last-slice flag.
module slice_stream_loader_index_counter
    import slice_stream_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] idx_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] idx_q;

    assign idx_o  = idx_q;
    assign last_o = (idx_q == ADDR_W'(DEPTH - 1));

    // Never wraps inside a run; the next run restarts through clr_i.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
        end else if (clr_i) begin
            idx_q <= '0;
        end else if (inc_i && !last_o) begin
            idx_q <= idx_q + 1'b1;
        end
    end

endmodule

// File: rtl/slice_stream_loader.sv
// Feeds state slices from the input memory to the controller/datapath pair and
// writes each datapath result to the output memory at the slice's own index.
module slice_stream_loader
    import slice_stream_loader_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    slice_stream_loader_if.master bus,
    output logic [2:0]            dbg_state_o
);

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    logic [2:0]        state_q, state_d;
    logic [WIDTH-1:0]  line_q, line_d;
    logic [WIDTH-1:0]  wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [1:0]        lat_q, lat_d;
    logic              line_valid_q, line_valid_d;
    logic              wr_en_q, wr_en_d;
    logic              busy_q, busy_d;
    logic              finished_q, finished_d;
    logic [ADDR_W-1:0] idx;
    logic              idx_clr, idx_inc, idx_last;

    slice_stream_loader_index_counter u_index (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (idx_clr),
        .inc_i  (idx_inc),
        .idx_o  (idx),
        .last_o (idx_last)
    );

    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        count_d      = count_q;
        line_valid_d = line_valid_q;
        lat_d        = lat_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        busy_d       = busy_q;
        finished_d   = 1'b0;
        idx_clr      = 1'b0;
        idx_inc      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                    busy_d  = 1'b1;
                    idx_clr = 1'b1;
                end
            end
            S_FETCH: begin
                state_d = S_WAIT;
                lat_d   = '0;
            end
            S_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    line_d       = bus.in_rd_data;
                    count_d      = idx;
                    line_valid_d = 1'b1;
                    state_d      = S_PRESENT;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_PRESENT: begin
                // An ok arriving with readLine completes the slice straight away.
                if (bus.readLine && bus.ok) begin
                    wr_en_d      = 1'b1;
                    wr_addr_d    = count_q;
                    wr_data_d    = bus.result;
                    line_valid_d = 1'b0;
                    state_d      = S_NEXT;
                end else if (bus.readLine) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (bus.ok) begin
                    wr_en_d      = 1'b1;
                    wr_addr_d    = count_q;
                    wr_data_d    = bus.result;
                    line_valid_d = 1'b0;
                    state_d      = S_NEXT;
                end
            end
            S_NEXT: begin
                line_valid_d = 1'b0;
                if (idx_last) begin
                    state_d    = S_DONE;
                    busy_d     = 1'b0;
                    finished_d = 1'b1;
                end else begin
                    idx_inc = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            line_q       <= '0;
            count_q      <= '0;
            line_valid_q <= 1'b0;
            lat_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            finished_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            count_q      <= count_d;
            line_valid_q <= line_valid_d;
            lat_q        <= lat_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            finished_q   <= finished_d;
        end
    end

    assign bus.in_rd_en    = (state_q == S_FETCH);
    assign bus.in_rd_addr  = idx;
    assign bus.line        = line_q;
    assign bus.count       = count_q;
    assign bus.line_valid  = line_valid_q;
    assign bus.out_wr_en   = wr_en_q;
    assign bus.out_wr_addr = wr_addr_q;
    assign bus.out_wr_data = wr_data_q;
    assign bus.busy        = busy_q;
    assign bus.finished    = finished_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_slice_stream_loader.sv
// Bench for slice_stream_loader: one instance per read latency, a memory model each,
// and a scoreboard of expected output writes built from the slices it hands out.
module tb_slice_stream_loader;
    import slice_stream_loader_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic             read_line = 1'b0;
    logic             ok = 1'b0;
    logic             sel = 1'b0;
    logic [WIDTH-1:0] result = '0;

    int errors = 0;
    int checks = 0;
    int exp_idx = 0;

    // ---------------- DUTs and memory models ----------------
    slice_stream_loader_if if1 ();
    slice_stream_loader_if if2 ();
    logic [2:0] dbg1, dbg2;

    slice_stream_loader #(.RD_LAT(1)) u_dut1 (.clk(clk), .rst(rst_n), .bus(if1), .dbg_state_o(dbg1));
    slice_stream_loader #(.RD_LAT(2)) u_dut2 (.clk(clk), .rst(rst_n), .bus(if2), .dbg_state_o(dbg2));

    assign if1.start    = start & ~sel;
    assign if2.start    = start & sel;
    assign if1.readLine = read_line;
    assign if2.readLine = read_line;
    assign if1.ok       = ok;
    assign if2.ok       = ok;
    assign if1.result   = result;
    assign if2.result   = result;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  rd1, rd2;
    logic              p2_en;
    logic [ADDR_W-1:0] p2_a;

    always @(posedge clk) begin
        if (if1.in_rd_en) rd1 <= mem[if1.in_rd_addr];
        p2_en <= if2.in_rd_en;
        p2_a  <= if2.in_rd_addr;
        if (p2_en) rd2 <= mem[p2_a];
    end
    assign if1.in_rd_data = rd1;
    assign if2.in_rd_data = rd2;

    // Observed view of whichever instance is under test.
    logic [WIDTH-1:0]  m_line, m_wr_data;
    logic [ADDR_W-1:0] m_count, m_rd_addr, m_wr_addr;
    logic              m_lv, m_rd_en, m_wr_en, m_busy, m_fin;
    logic [2:0]        m_state;
    assign m_line    = sel ? if2.line        : if1.line;
    assign m_count   = sel ? if2.count       : if1.count;
    assign m_lv      = sel ? if2.line_valid  : if1.line_valid;
    assign m_rd_en   = sel ? if2.in_rd_en    : if1.in_rd_en;
    assign m_rd_addr = sel ? if2.in_rd_addr  : if1.in_rd_addr;
    assign m_wr_en   = sel ? if2.out_wr_en   : if1.out_wr_en;
    assign m_wr_addr = sel ? if2.out_wr_addr : if1.out_wr_addr;
    assign m_wr_data = sel ? if2.out_wr_data : if1.out_wr_data;
    assign m_busy    = sel ? if2.busy        : if1.busy;
    assign m_fin     = sel ? if2.finished    : if1.finished;
    assign m_state   = sel ? dbg2            : dbg1;

    // ---------------- scoreboard ----------------
    logic [ADDR_W+WIDTH-1:0] exp_q[$];
    logic [ADDR_W+WIDTH-1:0] wr_log[$];
    int                      fin_cnt = 0;
    logic [ADDR_W-1:0]       last_wr_addr = '0;
    logic [ADDR_W-1:0]       fin_addr = '0;

    always @(negedge clk) begin
        if (m_wr_en) begin
            wr_log.push_back({m_wr_addr, m_wr_data});
            last_wr_addr <= m_wr_addr;
        end
        if (m_fin) begin
            fin_cnt  <= fin_cnt + 1;
            fin_addr <= last_wr_addr;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic serve_slice(input int rl_delay, input int ok_delay, input bit together, input int lat);
        int                n;
        logic [ADDR_W-1:0] ea;
        logic [WIDTH-1:0]  exp_line;
        logic [WIDTH-1:0]  r;
        ea       = ADDR_W'(exp_idx);
        exp_line = mem[ea];
        n = 0;
        do begin cyc(); n++; end while (!m_rd_en && n < 20);
        start = 1'b0;
        checks++;
        if (m_rd_en !== 1'b1 || m_rd_addr !== ea || n != 1) begin
            errors++;
            $display("FAIL fetch slice %0d: rd_en=%0b addr=%0d wait=%0d, required rd_en=1 addr=%0d wait=1",
                     exp_idx, m_rd_en, m_rd_addr, n, ea);
        end
        n = 0;
        do begin cyc(); n++; end while (!m_lv && n < 20);
        checks++;
        if (n != lat + 1 || m_line !== exp_line || m_count !== ea) begin
            errors++;
            $display("FAIL present slice %0d: latency=%0d line=%h count=%0d, required latency=%0d line=%h count=%0d",
                     exp_idx, n, m_line, m_count, lat + 1, exp_line, ea);
        end
        repeat (rl_delay) begin
            checks++;
            if (m_line !== exp_line || m_count !== ea || m_lv !== 1'b1 || m_rd_en !== 1'b0 || m_wr_en !== 1'b0) begin
                errors++;
                $display("FAIL hold slice %0d: line=%h count=%0d lv=%0b rd_en=%0b wr_en=%0b, required line=%h count=%0d lv=1 rd_en=0 wr_en=0",
                         exp_idx, m_line, m_count, m_lv, m_rd_en, m_wr_en, exp_line, ea);
            end
            cyc();
        end
        r = WIDTH'($urandom);
        read_line = 1'b1;
        if (together) begin
            ok     = 1'b1;
            result = r;
        end
        cyc();
        read_line = 1'b0;
        ok        = 1'b0;
        if (!together) begin
            repeat (ok_delay) begin
                checks++;
                if (m_wr_en !== 1'b0 || m_lv !== 1'b1 || m_line !== exp_line) begin
                    errors++;
                    $display("FAIL exec slice %0d: wr_en=%0b lv=%0b line=%h, required wr_en=0 lv=1 line=%h",
                             exp_idx, m_wr_en, m_lv, m_line, exp_line);
                end
                cyc();
            end
            ok     = 1'b1;
            result = r;
            cyc();
            ok = 1'b0;
        end
        exp_q.push_back({ea, r});
        checks++;
        if (m_wr_en !== 1'b1 || m_wr_addr !== ea || m_wr_data !== r || m_lv !== 1'b0 || m_busy !== 1'b1) begin
            errors++;
            $display("FAIL write slice %0d: wr_en=%0b addr=%0d data=%h lv=%0b busy=%0b, required wr_en=1 addr=%0d data=%h lv=0 busy=1",
                     exp_idx, m_wr_en, m_wr_addr, m_wr_data, m_lv, m_busy, ea, r);
        end
        exp_idx++;
    endtask

    // mode 0: fixed timing, mode 1: randomized timing, mode 2: fixed with a long stall on slice 7
    task automatic run_all(input int mode);
        int rl, okd, lat;
        bit tog;
        lat     = sel ? 2 : 1;
        exp_idx = 0;
        start   = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            rl = 1; okd = 4; tog = 1'b0;
            if (mode == 1) begin
                rl  = $urandom_range(0, 3);
                okd = $urandom_range(0, 4);
                tog = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            if (mode == 2 && i == 7) rl = 20;
            serve_slice(rl, okd, tog, lat);
        end
        cyc();
        checks++;
        if (m_fin !== 1'b1 || m_busy !== 1'b0 || m_state !== S_DONE) begin
            errors++;
            $display("FAIL done: finished=%0b busy=%0b state=%0d, required finished=1 busy=0 state=%0d",
                     m_fin, m_busy, m_state, S_DONE);
        end
        cyc();
        checks++;
        if (m_fin !== 1'b0 || m_busy !== 1'b0 || m_state !== S_IDLE) begin
            errors++;
            $display("FAIL idle after done: finished=%0b busy=%0b state=%0d, required 0 0 %0d",
                     m_fin, m_busy, m_state, S_IDLE);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        cyc(); cyc();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_line, m_count, m_lv, m_rd_en, m_rd_addr} !== '0) begin
            errors++;
            $display("FAIL reset input side: line=%h count=%0d lv=%0b rd_en=%0b rd_addr=%0d, required all 0",
                     m_line, m_count, m_lv, m_rd_en, m_rd_addr);
        end
        checks++;
        if ({m_wr_en, m_wr_addr, m_wr_data, m_busy, m_fin, m_state} !== '0) begin
            errors++;
            $display("FAIL reset output side: wr_en=%0b wr_addr=%0d wr_data=%h busy=%0b fin=%0b state=%0d, required all 0",
                     m_wr_en, m_wr_addr, m_wr_data, m_busy, m_fin, m_state);
        end
        cyc(); cyc();
        rst_n = 1'b1;
        cyc(); cyc();
        checks++;
        if (m_state !== S_IDLE || m_busy !== 1'b0 || m_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL idle without start: state=%0d busy=%0b rd_en=%0b, required %0d 0 0",
                     m_state, m_busy, m_rd_en, S_IDLE);
        end
    endtask

    task automatic test_full_run(input int mode);
        int base, base_fin;
        exp_q.delete();
        base     = wr_log.size();
        base_fin = fin_cnt;
        run_all(mode);
        checks++;
        if (wr_log.size() - base != DEPTH) begin
            errors++;
            $display("FAIL write count mode %0d: got %0d, required %0d", mode, wr_log.size() - base, DEPTH);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (base + i >= wr_log.size() || wr_log[base + i] !== exp_q[i]) begin
                errors++;
                $display("FAIL write log %0d mode %0d: got %h, required %h", i, mode,
                         (base + i < wr_log.size()) ? wr_log[base + i] : '0, exp_q[i]);
            end
        end
        checks++;
        if (fin_cnt - base_fin != 1 || fin_addr !== ADDR_W'(DEPTH - 1)) begin
            errors++;
            $display("FAIL finished pulses mode %0d: count=%0d after addr %0d, required 1 after addr %0d",
                     mode, fin_cnt - base_fin, fin_addr, DEPTH - 1);
        end
    endtask

    task automatic test_reset_mid();
        int base, n;
        exp_q.delete();
        base    = wr_log.size();
        exp_idx = 0;
        start   = 1'b1;
        for (int i = 0; i < 30; i++) serve_slice(1, 4, 1'b0, 1);
        n = 0;
        do begin cyc(); n++; end while (!m_lv && n < 20);
        read_line = 1'b1;
        cyc();
        read_line = 1'b0;
        cyc();
        checks++;
        if (m_state !== S_EXEC || m_count !== ADDR_W'(30)) begin
            errors++;
            $display("FAIL exec slice 30: state=%0d count=%0d, required %0d 30", m_state, m_count, S_EXEC);
        end
        ok     = 1'b1;
        result = WIDTH'($urandom);
        rst_n  = 1'b0;
        #1;
        checks++;
        if ({m_line, m_count, m_lv, m_rd_en, m_rd_addr, m_wr_en, m_wr_addr, m_wr_data, m_busy, m_fin, m_state} !== '0) begin
            errors++;
            $display("FAIL async reset mid-run: line=%h count=%0d lv=%0b wr_en=%0b wr_addr=%0d busy=%0b state=%0d, required all 0",
                     m_line, m_count, m_lv, m_wr_en, m_wr_addr, m_busy, m_state);
        end
        cyc();
        ok    = 1'b0;
        rst_n = 1'b1;
        cyc();
        checks++;
        if (wr_log.size() - base != 30) begin
            errors++;
            $display("FAIL aborted run writes: got %0d, required 30", wr_log.size() - base);
        end
        run_all(0);
        checks++;
        if (wr_log.size() - base != exp_q.size()) begin
            errors++;
            $display("FAIL rerun write count: got %0d, required %0d", wr_log.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (base + i >= wr_log.size() || wr_log[base + i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rerun write log %0d: got %h, required %h", i,
                         (base + i < wr_log.size()) ? wr_log[base + i] : '0, exp_q[i]);
            end
        end
    endtask

    task automatic test_ignored_pulses();
        int base;
        base   = wr_log.size();
        ok     = 1'b1;
        result = WIDTH'($urandom);
        cyc();
        ok = 1'b0;
        checks++;
        if (m_state !== S_IDLE || m_wr_en !== 1'b0 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL ok in idle: state=%0d wr_en=%0b busy=%0b, required %0d 0 0", m_state, m_wr_en, m_busy, S_IDLE);
        end
        start = 1'b1;
        cyc();
        start     = 1'b0;
        read_line = 1'b1;
        checks++;
        if (m_state !== S_FETCH || m_rd_en !== 1'b1 || m_rd_addr !== '0) begin
            errors++;
            $display("FAIL fetch after start: state=%0d rd_en=%0b addr=%0d, required %0d 1 0", m_state, m_rd_en, m_rd_addr, S_FETCH);
        end
        cyc();
        read_line = 1'b0;
        checks++;
        if (m_state !== S_WAIT || m_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL readLine in fetch: state=%0d wr_en=%0b, required %0d 0", m_state, m_wr_en, S_WAIT);
        end
        cyc(); cyc();
        checks++;
        if (m_state !== S_PRESENT || m_lv !== 1'b1 || m_line !== mem[0] || m_count !== '0) begin
            errors++;
            $display("FAIL still presenting: state=%0d lv=%0b line=%h count=%0d, required %0d 1 %h 0",
                     m_state, m_lv, m_line, m_count, S_PRESENT, mem[0]);
        end
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        checks++;
        if (wr_log.size() != base || m_state !== S_IDLE) begin
            errors++;
            $display("FAIL stray writes: got %0d writes state=%0d, required 0 writes state %0d",
                     wr_log.size() - base, m_state, S_IDLE);
        end
    endtask

    task automatic test_rd_lat2();
        sel = 1'b1;
        cyc();
        for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);
        mem[DEPTH - 1] = 25'h1FFFFFF;
        test_full_run(1);
        sel = 1'b0;
        cyc();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i + 1);
        test_reset();
        test_full_run(0);
        test_full_run(2);
        test_full_run(1);
        test_reset_mid();
        test_ignored_pulses();
        test_rd_lat2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
